// File: rtl/ifmap_spad_ctrl.sv
// ifmap_spad_ctrl
// ---------------
// This block sequences one PE's ifmap scratch pad. The scratch pad holds DEPTH entries,
// writes on the negative edge and has a single address port shared with its write enable.
//
// Operation:
//   FILL  Takes a row of W ifmap words through a valid/ready handshake.
//         Writes them to spad addresses 0..W-1.
//   READ  Replays the row toward the MAC as a 1-D sliding window
//         (filter width S, stride T). Each beat carries first/last/last-window tags.
//   DONE  Pulses done for one cycle. err is raised with it when the config was illegal.
//
// Optional feature (macro IFMAP_SPAD_CTRL_REUSE_EN):
//   Adds input port 'reuse'. A start with reuse=1 skips FILL. It replays the row left in
//   the spad by the last completed FILL, using the new S/T.
//
// Ports:
//   clk, reset                  clock (posedge) and synchronous active-high reset
//   start, cfg_width/filt/stride   start pulse and row config (W, S, T)
//   in_valid, in_data, in_ready    ifmap input handshake
//   spad_addr, spad_we, spad_data_in, spad_data_out   scratch pad interface
//   mac_valid, mac_ready, mac_data, mac_first, mac_last, mac_last_win   MAC side
//   busy, done, err             status
module ifmap_spad_ctrl #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEPTH  = 12,
  parameter int unsigned AW     = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [3:0]        cfg_width,
  input  logic [3:0]        cfg_filt,
  input  logic [1:0]        cfg_stride,
`ifdef IFMAP_SPAD_CTRL_REUSE_EN
  input  logic              reuse,
`endif
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic [AW-1:0]     spad_addr,
  output logic              spad_we,
  output logic [DATA_W-1:0] spad_data_in,
  input  logic [DATA_W-1:0] spad_data_out,
  output logic              mac_valid,
  input  logic              mac_ready,
  output logic [DATA_W-1:0] mac_data,
  output logic              mac_first,
  output logic              mac_last,
  output logic              mac_last_win,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] DepthC = CW'(DEPTH);

  typedef enum logic [1:0] {StIdle, StFill, StRead, StDone} state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] w_q, w_d, s_q, s_d, p_q, p_d;
  logic [1:0]    t_q, t_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] tap_q, tap_d, win_q, win_d;
  // Window base (win*T) and current read address (base+tap) are tracked incrementally.
  logic [AW-1:0] base_q, base_d, rd_addr_q, rd_addr_d;
  logic          err_q, err_d;
  // Set once a FILL has completed since reset. fill_w_q holds that row's length.
  logic          filled_q, filled_d;
  logic [CW-1:0] fill_w_q, fill_w_d;

  logic          reuse_req;
  logic [CW-1:0] src_w;
  logic          legal;
  logic [AW-1:0] t_ext;

`ifdef IFMAP_SPAD_CTRL_REUSE_EN
  assign reuse_req = reuse;
`else
  assign reuse_req = 1'b0;
`endif

  assign t_ext = AW'(t_q);

  // Number of windows P = floor((W-S)/T) + 1. Only used with S <= W and T in 1..3.
  function automatic logic [CW-1:0] calc_p(input logic [CW-1:0] w, input logic [CW-1:0] s,
                                           input logic [1:0] t);
    logic [CW-1:0] d;
    d = w - s;
    case (t)
      2'd2:    calc_p = (d >> 1) + 4'd1;
      2'd3:    calc_p = (d / 4'd3) + 4'd1;
      default: calc_p = d + 4'd1;
    endcase
  endfunction

  // A reuse request is checked against the length of the retained row.
  always_comb begin
    src_w = reuse_req ? fill_w_q : cfg_width;
    legal = (src_w != 4'd0) && (src_w <= DepthC) && (cfg_filt != 4'd0) &&
            (cfg_filt <= src_w) && (cfg_stride != 2'd0) && (!reuse_req || filled_q);
  end

  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    s_d       = s_q;
    t_d       = t_q;
    p_d       = p_q;
    wr_ptr_d  = wr_ptr_q;
    tap_d     = tap_q;
    win_d     = win_q;
    base_d    = base_q;
    rd_addr_d = rd_addr_q;
    err_d     = err_q;
    filled_d  = filled_q;
    fill_w_d  = fill_w_q;

    case (state_q)
      StIdle: begin
        if (start) begin
          w_d   = src_w;
          s_d   = cfg_filt;
          t_d   = cfg_stride;
          err_d = !legal;
          if (!legal) begin
            state_d = StDone;
          end else if (reuse_req) begin
            state_d   = StRead;
            tap_d     = '0;
            win_d     = '0;
            base_d    = '0;
            rd_addr_d = '0;
            p_d       = calc_p(src_w, cfg_filt, cfg_stride);
          end else begin
            state_d  = StFill;
            wr_ptr_d = '0;
          end
        end
      end
      StFill: begin
        if (in_valid) begin
          wr_ptr_d = wr_ptr_q + AW'(1);
          if (wr_ptr_q == AW'(w_q - 4'd1)) begin
            state_d   = StRead;
            tap_d     = '0;
            win_d     = '0;
            base_d    = '0;
            rd_addr_d = '0;
            p_d       = calc_p(w_q, s_q, t_q);
            filled_d  = 1'b1;
            fill_w_d  = w_q;
          end
        end
      end
      StRead: begin
        if (mac_ready) begin
          if (tap_q == s_q - 4'd1) begin
            tap_d     = '0;
            win_d     = win_q + 4'd1;
            base_d    = base_q + t_ext;
            rd_addr_d = base_q + t_ext;
            if (win_q == p_q - 4'd1) begin
              state_d = StDone;
            end
          end else begin
            tap_d     = tap_q + 4'd1;
            rd_addr_d = rd_addr_q + AW'(1);
          end
        end
      end
      StDone: begin
        state_d = StIdle;
        err_d   = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      w_q       <= '0;
      s_q       <= '0;
      t_q       <= '0;
      p_q       <= '0;
      wr_ptr_q  <= '0;
      tap_q     <= '0;
      win_q     <= '0;
      base_q    <= '0;
      rd_addr_q <= '0;
      err_q     <= 1'b0;
      filled_q  <= 1'b0;
      fill_w_q  <= '0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      s_q       <= s_d;
      t_q       <= t_d;
      p_q       <= p_d;
      wr_ptr_q  <= wr_ptr_d;
      tap_q     <= tap_d;
      win_q     <= win_d;
      base_q    <= base_d;
      rd_addr_q <= rd_addr_d;
      err_q     <= err_d;
      filled_q  <= filled_d;
      fill_w_q  <= fill_w_d;
    end
  end

  // Outputs decode flops only, except the write enable and the data passthroughs.
  always_comb begin
    in_ready     = (state_q == StFill);
    spad_we      = (state_q == StFill) && in_valid;
    spad_data_in = in_data;
    mac_data     = spad_data_out;
    mac_valid    = (state_q == StRead);
    mac_first    = (state_q == StRead) && (tap_q == 4'd0);
    mac_last     = (state_q == StRead) && (tap_q == s_q - 4'd1);
    mac_last_win = (state_q == StRead) && (win_q == p_q - 4'd1);
    busy         = (state_q != StIdle);
    done         = (state_q == StDone);
    err          = (state_q == StDone) && err_q;
    case (state_q)
      StFill:  spad_addr = wr_ptr_q;
      StRead:  spad_addr = rd_addr_q;
      default: spad_addr = '0;
    endcase
  end

endmodule

// File: tb/tb_ifmap_spad_ctrl.sv
module tb_ifmap_spad_ctrl;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [3:0]  cfg_width = '0, cfg_filt = '0;
  logic [1:0]  cfg_stride = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic [3:0]  spad_addr;
  logic        spad_we;
  logic [15:0] spad_data_in;
  logic [15:0] spad_data_out;
  logic        mac_valid;
  logic        mac_ready = 1'b0;
  logic [15:0] mac_data;
  logic        mac_first, mac_last, mac_last_win, busy, done, err;
`ifdef IFMAP_SPAD_CTRL_REUSE_EN
  logic        reuse = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;
  int row [16];

  always #5 clk = ~clk;

  ifmap_spad_ctrl #(.DATA_W(16), .DEPTH(12), .AW(4)) dut (
    .clk(clk), .reset(reset), .start(start),
    .cfg_width(cfg_width), .cfg_filt(cfg_filt), .cfg_stride(cfg_stride),
`ifdef IFMAP_SPAD_CTRL_REUSE_EN
    .reuse(reuse),
`endif
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .spad_addr(spad_addr), .spad_we(spad_we), .spad_data_in(spad_data_in),
    .spad_data_out(spad_data_out),
    .mac_valid(mac_valid), .mac_ready(mac_ready), .mac_data(mac_data),
    .mac_first(mac_first), .mac_last(mac_last), .mac_last_win(mac_last_win),
    .busy(busy), .done(done), .err(err)
  );

  // Scratch pad: 12 x 16, written and read on the negative edge.
  logic [15:0] mem [12];
  logic [15:0] spad_q = '0;
  assign spad_data_out = spad_q;
  always @(negedge clk) begin
    if (spad_addr < 4'd12) begin
      if (spad_we) mem[spad_addr] <= spad_data_in;
      spad_q <= mem[spad_addr];
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".in_ready"}, in_ready, 0);
    check({tag, ".spad_we"}, spad_we, 0);
    check({tag, ".spad_addr"}, spad_addr, 0);
    check({tag, ".mac_valid"}, mac_valid, 0);
    check({tag, ".tags"}, {mac_first, mac_last, mac_last_win}, 0);
    check({tag, ".status"}, {busy, done, err}, 0);
  endtask

  task automatic pulse_start(input int w, input int s, input int t, input bit reuse_f);
    start = 1'b1;
    cfg_width = 4'(w);
    cfg_filt = 4'(s);
    cfg_stride = 2'(t);
`ifdef IFMAP_SPAD_CTRL_REUSE_EN
    reuse = reuse_f;
`endif
    @(negedge clk); #1;
    check("idle.busy", busy, 0);
    @(posedge clk); #1;
    start = 1'b0;
`ifdef IFMAP_SPAD_CTRL_REUSE_EN
    reuse = 1'b0;
`endif
  endtask

  // mode 0: no stalls, 1: random stalls, 2: in_valid low for fill cycles 2..3 and
  // mac_ready low for 3 cycles at beat 4. abort_beat >= 0 resets the DUT at that beat.
  task automatic run_row(input int w, input int s, input int t, input int mode,
                         input int abort_beat, input int base, input bit reuse_f);
    int ea[$];
    int ef[$];
    int el[$];
    int ew[$];
    int np, idx, b, cyc, hold;
    bit v, r;
    if (!reuse_f)
      for (int i = 0; i < w; i++) row[i] = (base >= 0) ? base + i : int'($urandom_range(0, 65535));
    np = (w - s) / t + 1;
    for (int p = 0; p < np; p++)
      for (int k = 0; k < s; k++) begin
        ea.push_back(p * t + k);
        ef.push_back(k == 0);
        el.push_back(k == s - 1);
        ew.push_back(p == np - 1);
      end
    pulse_start(w, s, t, reuse_f);
    idx = 0;
    cyc = 0;
    while (!reuse_f && idx < w && cyc < 400) begin
      v = (mode == 1) ? ($urandom_range(0, 3) != 0) : !(mode == 2 && (cyc == 2 || cyc == 3));
      in_valid = v;
      in_data = 16'(row[idx]);
      @(negedge clk); #1;
      check("fill.in_ready", in_ready, 1);
      check("fill.spad_we", spad_we, 32'(v));
      if (v) check("fill.spad_addr", spad_addr, idx);
      @(posedge clk); #1;
      if (v) idx++;
      cyc++;
    end
    in_valid = 1'b0;
    if (!reuse_f) check("fill.words_written", idx, w);
    b = 0;
    hold = 0;
    cyc = 0;
    while (b < ea.size() && cyc < 800) begin
      if (b == abort_beat) begin
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        @(negedge clk); #1;
        check_all_zero("abort");
        @(posedge clk); #1;
        mac_ready = 1'b0;
        return;
      end
      if (mode == 1) r = ($urandom_range(0, 3) != 0);
      else r = !(mode == 2 && b == 4 && hold < 3);
      if (!r) hold++;
      mac_ready = r;
      @(negedge clk); #1;
      check("read.mac_valid", mac_valid, 1);
      check("read.in_ready", in_ready, 0);
      check("read.spad_we", spad_we, 0);
      check("read.spad_addr", spad_addr, ea[b]);
      check("read.mac_data", mac_data, row[ea[b]]);
      check("read.tags", {mac_first, mac_last, mac_last_win}, {ef[b][0], el[b][0], ew[b][0]});
      @(posedge clk); #1;
      if (r) b++;
      cyc++;
    end
    mac_ready = 1'b0;
    check("read.beats", b, ea.size());
    @(negedge clk); #1;
    check("done.pulse", {busy, done, err}, 3'b110);
    check("done.mac_valid", mac_valid, 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("after_done.status", {busy, done, err}, 0);
    @(posedge clk); #1;
  endtask

  task automatic illegal(input int w, input int s, input int t, input bit reuse_f);
    pulse_start(w, s, t, reuse_f);
    in_valid = 1'b1;
    @(negedge clk); #1;
    check("illegal.done_err", {done, err}, 2'b11);
    check("illegal.in_ready", in_ready, 0);
    check("illegal.spad_we", spad_we, 0);
    @(posedge clk); #1;
    @(negedge clk); #1;
    check("illegal.after", {busy, done, err, in_ready, spad_we}, 0);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk); #1;
    check_all_zero("reset");
    @(posedge clk); #1;
`ifdef IFMAP_SPAD_CTRL_REUSE_EN
    illegal(6, 2, 2, 1'b1);
`endif
    run_row(5, 3, 1, 0, -1, 10, 1'b0);
    run_row(7, 3, 2, 0, -1, -1, 1'b0);
    run_row(8, 3, 3, 0, -1, -1, 1'b0);
    run_row(8, 3, 1, 2, -1, -1, 1'b0);
    illegal(4, 6, 1, 1'b0);
    illegal(5, 2, 0, 1'b0);
    illegal(0, 1, 1, 1'b0);
    illegal(13, 1, 1, 1'b0);
    illegal(5, 0, 1, 1'b0);
    run_row(6, 2, 1, 0, 4, -1, 1'b0);
    run_row(3, 3, 1, 0, -1, -1, 1'b0);
    run_row(12, 1, 3, 0, -1, -1, 1'b0);
    run_row(12, 12, 1, 0, -1, -1, 1'b0);
    run_row(1, 1, 1, 0, -1, -1, 1'b0);
`ifdef IFMAP_SPAD_CTRL_REUSE_EN
    run_row(6, 3, 1, 0, -1, -1, 1'b0);
    run_row(6, 2, 2, 0, -1, -1, 1'b1);
    illegal(6, 7, 1, 1'b1);
`endif
    for (int n = 0; n < 25; n++) begin
      int w, s, t;
      w = int'($urandom_range(1, 12));
      s = int'($urandom_range(1, w));
      t = int'($urandom_range(1, 3));
      run_row(w, s, t, 1, -1, -1, 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
